// File: rtl/display_decoder_if.sv
// Bus between the editable display register / board pins and the display decoder.
interface display_decoder_if;
  logic [15:0] value;
  logic [2:0]  cursor;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [19:0] bcd;
  logic        busy;

  modport master (output value, cursor, input seg, dp, an, bcd, busy);
  modport slave  (input value, cursor, output seg, dp, an, bcd, busy);
endinterface

// File: rtl/display_decoder.sv
// Serial double-dabble binary-to-BCD converter driving a 4-digit multiplexed,
// active-low 7-segment display with a blinking cursor digit.
module display_decoder #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic              CLK,
  input  logic              RESET,
  display_decoder_if.slave  bus
);

  localparam int unsigned VAL_W  = 16;
  localparam int unsigned BCD_W  = 20;
  localparam int unsigned SR_W   = BCD_W + VAL_W;
  localparam int unsigned ITER_W = 4;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned NDIG   = BCD_W / 4;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_e;

  state_e                state_q;
  logic [VAL_W-1:0]      last_q;
  logic [SR_W-1:0]       sr_q, sr_adj, sr_d;
  logic [ITER_W-1:0]     iter_q;
  logic [BCD_W-1:0]      bcd_q;
  logic                  busy_q;

  logic [SCAN_W-1:0]     scan_cnt_q;
  logic [1:0]            idx_q;
  logic [BLINK_BITS-1:0] blink_q;
  logic [3:0]            an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic [2:0]            cur;
  logic [2:0]            sel;
  logic [3:0]            nib;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble, then the one-bit shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (sr_q[VAL_W + 4*i +: 4] >= 4'd5)
        sr_adj[VAL_W + 4*i +: 4] = sr_q[VAL_W + 4*i +: 4] + 4'd3;
    end
    sr_d = sr_adj << 1;
  end

  // Converter FSM; a change seen while busy is picked up on the next IDLE cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      last_q  <= '0;
      sr_q    <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.value != last_q) begin
            last_q  <= bus.value;
            sr_q    <= {BCD_W'(0), bus.value};
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          sr_q   <= sr_d;
          iter_q <= iter_q + ITER_W'(1);
          if (iter_q == ITER_W'(VAL_W - 1))
            state_q <= S_DONE;
        end
        S_DONE: begin
          bcd_q   <= sr_q[SR_W-1 -: BCD_W];
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Digit selection: cursor 4 slides the window up by one digit.
  always_comb begin
    cur = (bus.cursor > 3'd4) ? 3'd4 : bus.cursor;
    sel = (cur == 3'd4) ? (3'(idx_q) + 3'd1) : 3'(idx_q);
    case (sel)
      3'd0:    nib = bcd_q[3:0];
      3'd1:    nib = bcd_q[7:4];
      3'd2:    nib = bcd_q[11:8];
      3'd3:    nib = bcd_q[15:12];
      default: nib = bcd_q[19:16];
    endcase
    an_d  = 4'(~(4'b0001 << idx_q));
    seg_d = seg_code(nib);
    if (blink_q[BLINK_BITS-1] && (sel == cur))
      seg_d = 7'b1111111;
    dp_d = 1'b1;
    if ((cur != 3'd4) && (bcd_q[19:16] != 4'd0) && (idx_q == 2'd3))
      dp_d = 1'b0;
    if ((cur == 3'd4) && (idx_q == 2'd0))
      dp_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      blink_q    <= '0;
      an_q       <= 4'b1110;
      seg_q      <= 7'b1000000;
      dp_q       <= 1'b1;
    end else begin
      if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        idx_q      <= idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
      end
      blink_q <= blink_q + BLINK_BITS'(1);
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
  assign bus.an   = an_q;
  assign bus.bcd  = bcd_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_display_decoder.sv
// Directed bench for display_decoder: conversion latency, restart, window, dp, blink, reset.
module tb_display_decoder;

  logic CLK = 1'b0;
  logic RESET;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  logic [6:0] seg_tab [10];

  display_decoder_if dif ();

  display_decoder #(.SCAN_DIV(4), .BLINK_BITS(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (dif)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    if (RESET) cyc = 0;
    else       cyc = cyc + 1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Value change -> busy next edge, bcd updated exactly 17 edges after that.
  task automatic convert(input string tag, input logic [15:0] v, input logic [19:0] exp_bcd);
    logic [19:0] old_bcd;
    old_bcd = dif.bcd;
    dif.value = v;
    tick();
    chk({tag, "_busy_rise"}, dif.busy, 1'b1);
    repeat (16) tick();
    chk({tag, "_bcd_hold"}, dif.bcd, old_bcd);
    chk({tag, "_busy_hold"}, dif.busy, 1'b1);
    tick();
    chk({tag, "_bcd"}, dif.bcd, exp_bcd);
    chk({tag, "_busy_fall"}, dif.busy, 1'b0);
  endtask

  // Outputs after post-reset edge k reflect idx and blink phase from edge k-1.
  task automatic scan(input string tag, input int n,
                      input logic [6:0] e0, input logic [6:0] e1,
                      input logic [6:0] e2, input logic [6:0] e3,
                      input int dp_pos, input int blink_pos);
    logic [6:0] exp_tab [4];
    int pos;
    logic blink;
    logic [6:0] exp_seg;
    exp_tab[0] = e0; exp_tab[1] = e1; exp_tab[2] = e2; exp_tab[3] = e3;
    for (int i = 0; i < n; i++) begin
      tick();
      pos   = ((cyc - 1) / 4) % 4;
      blink = (((cyc - 1) >> 3) & 1) != 0;
      exp_seg = (blink && pos == blink_pos) ? 7'b1111111 : exp_tab[pos];
      chk({tag, "_an"},  dif.an,  4'(~(4'b0001 << pos)));
      chk({tag, "_seg"}, dif.seg, exp_seg);
      chk({tag, "_dp"},  dif.dp,  (pos == dp_pos) ? 1'b0 : 1'b1);
    end
  endtask

  initial begin
    logic bad;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    // Reset
    RESET = 1'b1;
    dif.value = 16'd0;
    dif.cursor = 3'd0;
    tick();
    tick();
    chk("rst_an",   dif.an,   4'b1110);
    chk("rst_seg",  dif.seg,  7'b1000000);
    chk("rst_dp",   dif.dp,   1'b1);
    chk("rst_bcd",  dif.bcd,  20'h0);
    chk("rst_busy", dif.busy, 1'b0);
    RESET = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (dif.busy !== 1'b0) bad = 1'b1;
    end
    chk("rst_busy_stays_low", bad, 1'b0);

    // Conversion latency
    convert("c1111", 16'd1111, 20'h01111);
    convert("c1003", 16'd1003, 20'h01003);

    // Restart after a mid-conversion change
    convert("c0", 16'd0, 20'h00000);
    dif.value = 16'd1003;
    tick();
    chk("rs_busy_rise", dif.busy, 1'b1);
    repeat (5) tick();
    dif.value = 16'd20803;
    bad = 1'b0;
    repeat (11) begin
      tick();
      if (dif.busy !== 1'b1 || dif.bcd !== 20'h0) bad = 1'b1;
    end
    chk("rs_first_conv_clean", bad, 1'b0);
    tick();
    chk("rs_bcd_first", dif.bcd, 20'h01003);
    chk("rs_busy_gap", dif.busy, 1'b0);
    bad = 1'b0;
    repeat (17) begin
      tick();
      if (dif.busy !== 1'b1 || dif.bcd !== 20'h01003) bad = 1'b1;
    end
    chk("rs_second_conv_clean", bad, 1'b0);
    tick();
    chk("rs_bcd_second", dif.bcd, 20'h20803);
    chk("rs_busy_fall", dif.busy, 1'b0);

    // Window and dp
    convert("c65535", 16'd65535, 20'h65535);
    scan("win_c0", 32, seg_tab[5], seg_tab[3], seg_tab[5], seg_tab[5], 3, 0);
    dif.cursor = 3'd4;
    scan("win_c4", 32, seg_tab[3], seg_tab[5], seg_tab[5], seg_tab[6], 0, 3);
    dif.cursor = 3'd7;
    scan("win_c7", 16, seg_tab[3], seg_tab[5], seg_tab[5], seg_tab[6], 0, 3);

    // Blink on cursor digit
    dif.cursor = 3'd2;
    convert("c1203", 16'd1203, 20'h01203);
    scan("blink_c2", 32, seg_tab[3], seg_tab[0], seg_tab[2], seg_tab[1], -1, 2);

    // Reset mid-conversion
    dif.value = 16'd21003;
    tick();
    chk("rm_busy_rise", dif.busy, 1'b1);
    repeat (8) tick();
    RESET = 1'b1;
    tick();
    chk("rm_bcd_cleared", dif.bcd, 20'h0);
    chk("rm_busy_cleared", dif.busy, 1'b0);
    chk("rm_an", dif.an, 4'b1110);
    RESET = 1'b0;
    tick();
    chk("rm_busy_restart", dif.busy, 1'b1);
    repeat (16) tick();
    chk("rm_bcd_hold", dif.bcd, 20'h0);
    tick();
    chk("rm_bcd", dif.bcd, 20'h21003);
    chk("rm_busy_fall", dif.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
